// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stop_watch UART remote-control bridge.
package stopwatch_pkg;

   // stop_watch mode encoding (one-hot, as driven by the stop_watch FSM)
   typedef enum logic [2:0] {
      IDLE    = 3'b100,
      RUNNING = 3'b001,
      CLEAR   = 3'b010
   } state_t;

   typedef enum logic {
      RX_IDLE  = 1'b0,
      RX_GUARD = 1'b1
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_SEND  = 2'd1,
      TX_GUARD = 2'd2,
      TX_WAIT  = 2'd3
   } tx_state_t;

   // command bytes
   localparam logic [7:0] CMD_BTN_U = 8'h42;
   localparam logic [7:0] CMD_BTN_L = 8'h62;
   localparam logic [7:0] CMD_RPT_U = 8'h54;
   localparam logic [7:0] CMD_RPT_L = 8'h74;
   localparam logic [7:0] ASCII_CR  = 8'h0D;
   localparam logic [7:0] ASCII_LF  = 8'h0A;
   localparam logic [7:0] ASCII_0   = 8'h30;

   // report mode characters
   localparam logic [7:0] CHR_IDLE    = 8'h49;
   localparam logic [7:0] CHR_RUNNING = 8'h52;
   localparam logic [7:0] CHR_CLEAR   = 8'h43;
   localparam logic [7:0] CHR_UNKNOWN = 8'h3F;

   localparam int REPORT_LEN = 4;
   localparam int IDX_W      = 2;

   // Map a raw mode encoding to its report character; illegal encodings show '?'
   function automatic logic [7:0] mode_char(input logic [2:0] mode);
      case (mode)
         IDLE:    mode_char = CHR_IDLE;
         RUNNING: mode_char = CHR_RUNNING;
         CLEAR:   mode_char = CHR_CLEAR;
         default: mode_char = CHR_UNKNOWN;
      endcase
   endfunction

endpackage

// File: rtl/stopwatch_uart_link_bin2dec2.sv
// Binary to two BCD digits, saturating at 99.
module bin2dec2 #(
   parameter int TIME_W = 5
) (
   input  logic [TIME_W-1:0] bin,
   output logic [3:0]        tens,
   output logic [3:0]        ones
);

   logic [6:0] val;

   // divide by ten; anything above 99 clamps to "99"
   always_comb begin
      val = 7'(bin);
      if (val > 7'd99) begin
         tens = 4'd9;
         ones = 4'd9;
      end else begin
         tens = 4'(val / 7'd10);
         ones = 4'(val % 7'd10);
      end
   end

endmodule

// File: rtl/stopwatch_uart_link.sv
// UART byte interface <-> stop_watch bridge: command decode and status reports.
//
// state    | meaning
// ---------+----------------------------------------------------------
// RX_IDLE  | waiting for rxready_i; latches the byte when it appears
// RX_GUARD | acknowledge + decode cycle, rxready_i ignored
// TX_IDLE  | waiting for report_pending; takes the snapshot
// TX_SEND  | strobes byte[idx] as soon as the transmitter is ready
// TX_GUARD | one cycle for the UART to drop txready_i
// TX_WAIT  | waits for the byte to finish, then next byte or done
import stopwatch_pkg::*;

module stopwatch_uart_link #(
   parameter int TIME_W      = 5,
   parameter bit AUTO_REPORT = 1'b0
) (
   input  logic              clk,
   input  logic              nRst_i,
   input  logic [7:0]        rxdata_i,
   input  logic              rxready_i,
   output logic              rxclk_o,
   output logic [7:0]        txdata_o,
   input  logic              txready_i,
   output logic              txclk_o,
   input  logic [2:0]        mode_i,
   input  logic [TIME_W-1:0] time_i,
   output logic              button_o,
   output logic              rx_err_o
);

   rx_state_t         rx_state, rx_next;
   logic [7:0]        rx_byte;
   logic              rpt_req_rx;

   tx_state_t         tx_state, tx_next;
   logic [IDX_W-1:0]  idx;
   logic              idx_inc;
   logic              snap_take;
   logic [2:0]        snap_mode;
   logic [TIME_W-1:0] snap_time;
   logic [3:0]        tens, ones;
   logic [7:0]        cur_byte;

   logic              report_pending;
   logic              auto_req;

   // RX state register and byte latch
   always_ff @(posedge clk) begin
      if (!nRst_i) begin
         rx_state <= RX_IDLE;
         rx_byte  <= 8'h00;
      end else begin
         rx_state <= rx_next;
         if (rx_state == RX_IDLE && rxready_i)
            rx_byte <= rxdata_i;
      end
   end

   // RX next-state, acknowledge and command decode
   always_comb begin
      rx_next    = rx_state;
      rxclk_o    = 1'b0;
      button_o   = 1'b0;
      rx_err_o   = 1'b0;
      rpt_req_rx = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (rxready_i)
               rx_next = RX_GUARD;
         end
         RX_GUARD: begin
            rxclk_o = 1'b1;
            rx_next = RX_IDLE;
            case (rx_byte)
               CMD_BTN_U, CMD_BTN_L: button_o   = 1'b1;
               CMD_RPT_U, CMD_RPT_L: rpt_req_rx = 1'b1;
               ASCII_CR, ASCII_LF:   ;
               default:              rx_err_o   = 1'b1;
            endcase
         end
         default: rx_next = RX_IDLE;
      endcase
   end

   // Auto-report watches time_i against a registered copy
   if (AUTO_REPORT) begin : g_auto
      logic [TIME_W-1:0] prev_time;

      // previous-time copy for change detection
      always_ff @(posedge clk) begin
         if (!nRst_i)
            prev_time <= '0;
         else
            prev_time <= time_i;
      end

      assign auto_req = (time_i != prev_time);
   end else begin : g_no_auto
      assign auto_req = 1'b0;
   end

   // Single-deep request flag; a new request wins over the snapshot clear
   always_ff @(posedge clk) begin
      if (!nRst_i)
         report_pending <= 1'b0;
      else if (rpt_req_rx || auto_req)
         report_pending <= 1'b1;
      else if (snap_take)
         report_pending <= 1'b0;
   end

   // TX state register, byte index and frozen snapshot
   always_ff @(posedge clk) begin
      if (!nRst_i) begin
         tx_state  <= TX_IDLE;
         idx       <= '0;
         snap_mode <= 3'b000;
         snap_time <= '0;
      end else begin
         tx_state <= tx_next;
         if (snap_take) begin
            snap_mode <= mode_i;
            snap_time <= time_i;
            idx       <= '0;
         end else if (idx_inc) begin
            idx <= idx + 1'b1;
         end
      end
   end

   bin2dec2 #(.TIME_W(TIME_W)) u_bin2dec2 (
      .bin  (snap_time),
      .tens (tens),
      .ones (ones)
   );

   // Report byte selected by index
   always_comb begin
      case (idx)
         2'd0:    cur_byte = mode_char(snap_mode);
         2'd1:    cur_byte = ASCII_0 + {4'h0, tens};
         2'd2:    cur_byte = ASCII_0 + {4'h0, ones};
         default: cur_byte = ASCII_CR;
      endcase
   end

   // TX next-state and strobe
   always_comb begin
      tx_next   = tx_state;
      txclk_o   = 1'b0;
      txdata_o  = 8'h00;
      snap_take = 1'b0;
      idx_inc   = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (report_pending) begin
               snap_take = 1'b1;
               tx_next   = TX_SEND;
            end
         end
         TX_SEND: begin
            if (txready_i) begin
               txclk_o  = 1'b1;
               txdata_o = cur_byte;
               tx_next  = TX_GUARD;
            end
         end
         TX_GUARD: tx_next = TX_WAIT;
         TX_WAIT: begin
            if (txready_i) begin
               if (idx == IDX_W'(REPORT_LEN - 1)) begin
                  tx_next = TX_IDLE;
               end else begin
                  idx_inc = 1'b1;
                  tx_next = TX_SEND;
               end
            end
         end
         default: tx_next = TX_IDLE;
      endcase
   end

endmodule

// File: tb/tb_stopwatch_uart_link.sv
// Bench for stopwatch_uart_link: a manual-report instance and an auto-report instance.
module tb_stopwatch_uart_link;
   import stopwatch_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // manual-report instance (TIME_W=6 so 63 can be shown)
   logic       nrst;
   logic [7:0] rxdata;
   logic       rxready;
   logic       rxclk;
   logic [7:0] txdata;
   logic       txready;
   logic       txclk;
   logic [2:0] mode;
   logic [5:0] tval;
   logic       button;
   logic       rxerr;

   // auto-report instance
   logic       nrst_a;
   logic [7:0] rxdata_a = 8'h00;
   logic       rxready_a = 1'b0;
   logic       rxclk_a;
   logic [7:0] txdata_a;
   logic       txready_a;
   logic       txclk_a;
   logic [2:0] mode_a;
   logic [4:0] tval_a;
   logic       button_a;
   logic       rxerr_a;

   int drop = 10;
   int total = 0;
   int bad = 0;
   logic [7:0] q[$];
   logic [7:0] qa[$];
   logic [7:0] expb, expb_a;
   logic prev_tx = 1'b0;
   logic prev_tx_a = 1'b0;

   stopwatch_uart_link #(.TIME_W(6), .AUTO_REPORT(1'b0)) dut (
      .clk(clk), .nRst_i(nrst), .rxdata_i(rxdata), .rxready_i(rxready),
      .rxclk_o(rxclk), .txdata_o(txdata), .txready_i(txready), .txclk_o(txclk),
      .mode_i(mode), .time_i(tval), .button_o(button), .rx_err_o(rxerr)
   );

   stopwatch_uart_link #(.TIME_W(5), .AUTO_REPORT(1'b1)) dut_a (
      .clk(clk), .nRst_i(nrst_a), .rxdata_i(rxdata_a), .rxready_i(rxready_a),
      .rxclk_o(rxclk_a), .txdata_o(txdata_a), .txready_i(txready_a), .txclk_o(txclk_a),
      .mode_i(mode_a), .time_i(tval_a), .button_o(button_a), .rx_err_o(rxerr_a)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // UART transmitter models: busy for 'drop' cycles after each accepted byte
   initial begin
      txready = 1'b1;
      forever begin
         @(negedge clk);
         if (txclk) begin
            @(posedge clk);
            #1 txready = 1'b0;
            repeat (drop) @(posedge clk);
            #1 txready = 1'b1;
         end
      end
   end

   initial begin
      txready_a = 1'b1;
      forever begin
         @(negedge clk);
         if (txclk_a) begin
            @(posedge clk);
            #1 txready_a = 1'b0;
            repeat (drop) @(posedge clk);
            #1 txready_a = 1'b1;
         end
      end
   end

   // scoreboard monitors: each strobe pops one expected byte
   always @(negedge clk) begin
      if (prev_tx) chk("tx_pulse", txclk, 0);
      if (txclk) begin
         chk("tx_ready", txready, 1);
         if (q.size() == 0) begin
            chk("tx_unexp", q.size(), 1);
         end else begin
            expb = q.pop_front();
            chk("tx_byte", txdata, expb);
         end
      end
      prev_tx <= txclk;
   end

   always @(negedge clk) begin
      if (prev_tx_a) chk("txa_pulse", txclk_a, 0);
      if (txclk_a) begin
         chk("txa_ready", txready_a, 1);
         if (qa.size() == 0) begin
            chk("txa_unexp", qa.size(), 1);
         end else begin
            expb_a = qa.pop_front();
            chk("txa_byte", txdata_a, expb_a);
         end
      end
      prev_tx_a <= txclk_a;
   end

   task automatic push_rpt(input logic [7:0] c, input int t);
      q.push_back(c);
      q.push_back(8'(8'h30 + t / 10));
      q.push_back(8'(8'h30 + t % 10));
      q.push_back(8'h0D);
   endtask

   task automatic push_rpt_a(input logic [7:0] c, input int t);
      qa.push_back(c);
      qa.push_back(8'(8'h30 + t / 10));
      qa.push_back(8'(8'h30 + t % 10));
      qa.push_back(8'h0D);
   endtask

   // present a byte, check the ack cycle one edge later, then the cycle after
   task automatic send_byte(input logic [7:0] b, input int eb, input int ee);
      int n;
      n = 0;
      @(negedge clk);
      rxdata  = b;
      rxready = 1'b1;
      @(negedge clk);
      while (!rxclk && n < 4) begin
         @(negedge clk);
         n++;
      end
      chk("rx_lat", n, 0);
      chk("rx_ack", rxclk, 1);
      chk("rx_btn", button, eb);
      chk("rx_err", rxerr, ee);
      rxready = 1'b0;
      rxdata  = 8'h00;
      @(negedge clk);
      chk("rx_ack_end", rxclk, 0);
      chk("rx_btn_end", button, 0);
      chk("rx_err_end", rxerr, 0);
   endtask

   task automatic drain(input int lim);
      int n;
      n = 0;
      while (q.size() != 0 && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("drain", q.size(), 0);
   endtask

   task automatic drain_a(input int lim);
      int n;
      n = 0;
      while (qa.size() != 0 && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("drain_a", qa.size(), 0);
   endtask

   // 'T' latency: nothing in the cycle after the ack, strobe in the next one
   task automatic t_latency();
      chk("t_pre", txclk, 0);
      @(negedge clk);
      chk("t_lat", txclk, 1);
   endtask

   initial begin
      int n;
      nrst    = 1'b0;
      nrst_a  = 1'b0;
      rxready = 1'b1;
      rxdata  = CMD_BTN_U;
      mode    = 3'b100;
      tval    = 6'd0;
      mode_a  = 3'b100;
      tval_a  = 5'd0;

      // reset holds everything quiet even with a byte waiting
      repeat (3) begin
         @(negedge clk);
         chk("rst_rxclk", rxclk, 0);
         chk("rst_btn", button, 0);
         chk("rst_err", rxerr, 0);
         chk("rst_txclk", txclk, 0);
         chk("rst_txdata", txdata, 0);
      end
      nrst   = 1'b1;
      nrst_a = 1'b1;
      @(negedge clk);
      chk("rel_rxclk", rxclk, 1);
      chk("rel_btn", button, 1);
      rxready = 1'b0;
      @(negedge clk);
      chk("rel_rxclk_end", rxclk, 0);
      chk("rel_btn_end", button, 0);

      // unknown byte errors; CR and LF are silent
      send_byte(8'h78, 0, 1);
      send_byte(8'h0D, 0, 0);
      send_byte(8'h0A, 0, 0);

      // RUNNING, 17
      mode = 3'b001;
      tval = 6'd17;
      push_rpt(8'h52, 17);
      send_byte(CMD_RPT_U, 0, 0);
      t_latency();
      drain(300);
      repeat (20) @(negedge clk);

      // frozen snapshot plus collapsed follow-up request, button during TX
      mode = 3'b010;
      tval = 6'd5;
      push_rpt(8'h43, 5);
      send_byte(CMD_RPT_U, 0, 0);
      n = 0;
      while (q.size() > 3 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("mid_rpt", q.size(), 3);
      tval = 6'd9;
      push_rpt(8'h43, 9);
      send_byte(CMD_RPT_U, 0, 0);
      send_byte(CMD_BTN_L, 1, 0);
      send_byte(CMD_RPT_L, 0, 0);
      drain(400);
      repeat (60) @(negedge clk);

      // illegal mode encoding and the largest count
      mode = 3'b111;
      tval = 6'd63;
      push_rpt(8'h3F, 63);
      send_byte(CMD_RPT_L, 0, 0);
      drain(300);
      repeat (20) @(negedge clk);

      // auto-report on time change only
      tval_a = 5'd30;
      push_rpt_a(8'h49, 30);
      drain_a(300);
      repeat (50) @(negedge clk);
      tval_a = 5'd31;
      push_rpt_a(8'h49, 31);
      drain_a(300);
      repeat (30) @(negedge clk);

      // reset after the second byte aborts the report
      mode = 3'b001;
      tval = 6'd42;
      push_rpt(8'h52, 42);
      send_byte(CMD_RPT_U, 0, 0);
      n = 0;
      while (q.size() > 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("abort_point", q.size(), 2);
      nrst = 1'b0;
      q.delete();
      repeat (3) begin
         @(negedge clk);
         chk("abort_txclk", txclk, 0);
         chk("abort_rxclk", rxclk, 0);
      end
      nrst = 1'b1;
      repeat (60) @(negedge clk);

      // back to normal after the abort
      push_rpt(8'h52, 42);
      send_byte(CMD_RPT_U, 0, 0);
      t_latency();
      drain(300);
      repeat (20) @(negedge clk);

      chk("q_left", q.size() + qa.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/stopwatch_uart_link.md
Name: stopwatch_uart_link

Overview:
- Serial remote-control and readout bridge between the board UART byte interface and the stop_watch block.
- Receives ASCII command bytes and turns 'B' into a one-cycle button pulse, equivalent to a pb[0] press, that drives stop_watch button_i.
- On request, or automatically when enabled, transmits a 4-byte status report built from stop_watch mode_o and time_o.
- Sits in top between the UART ports and the stop_watch instance.

Parameters:
- TIME_W, 5: width of time_i. Legal range 1..6. Values 0..63 are rendered as two decimal digits, saturating at "99" (never reached for TIME_W ≤ 6).
- AUTO_REPORT, 0: when 1, a report is requested automatically whenever time_i changes.

Ports:
- clk, input, 1: system clock (hz100 at top).
- nRst_i, input, 1: synchronous active-low reset.
- rxdata_i, input, 8: received byte, valid while rxready_i=1.
- rxready_i, input, 1: UART has a received byte available.
- rxclk_o, output, 1: one-cycle acknowledge that consumes rxdata_i.
- txdata_o, output, 8: byte to transmit, valid while txclk_o=1.
- txready_i, input, 1: UART transmitter idle and able to accept a byte.
- txclk_o, output, 1: one-cycle strobe that loads txdata_o into the UART.
- mode_i, input, 3: stop_watch mode (state_t).
- time_i, input, TIME_W: stop_watch count.
- button_o, output, 1: one-cycle button pulse to stop_watch button_i.
- rx_err_o, output, 1: one-cycle pulse on an unrecognised command byte.

Behaviour:
- Single clock is clk. Reset is synchronous and active-low on nRst_i, sampled at the clk rising edge. All outputs are 0 in reset. Both FSMs return to idle. Pending report flag and snapshot registers clear.
- RX FSM, states RX_IDLE and RX_GUARD:
  - RX_IDLE: if rxready_i=1 at edge N, latch rxdata_i. In cycle N+1, rxclk_o=1 for exactly one cycle, and the FSM moves to RX_GUARD.
  - RX_GUARD: rxready_i is ignored for one cycle so the UART can drop ready. Then return to RX_IDLE.
  - Decode happens in the same N+1 cycle:
    - 0x42 'B' or 0x62 'b': button_o=1.
    - 0x54 'T' or 0x74 't': set report_pending.
    - 0x0D and 0x0A: ignored silently.
    - Any other byte: rx_err_o=1.
  - Maximum acceptance rate is one byte per 2 cycles.
- TX FSM, states TX_IDLE, TX_SEND, TX_GUARD, TX_WAIT:
  - TX_IDLE with report_pending=1:
    - Snapshot mode_i and time_i.
    - Clear report_pending.
    - Set byte index to 0.
    - Go to TX_SEND.
  - TX_SEND: when txready_i=1, drive txdata_o = byte[idx] with txclk_o=1 for one cycle, then go to TX_GUARD. If txready_i=0, hold without strobing.
  - TX_GUARD: one cycle with txready_i ignored, then go to TX_WAIT.
  - TX_WAIT: when txready_i=1, either increment idx and return to TX_SEND, or return to TX_IDLE if idx was 3.
  - Report byte 0, mode character:
    - IDLE 3'b100 → 'I' (0x49).
    - RUNNING 3'b001 → 'R' (0x52).
    - CLEAR 3'b010 → 'C' (0x43).
    - Any other encoding → '?' (0x3F).
  - Report bytes 1 and 2: tens digit then ones digit of the snapshotted time, as ASCII 0x30+d.
  - Report byte 3: CR (0x0D).
  - The snapshot is frozen for the whole report. Changes to time_i or mode_i during a report do not alter bytes in flight.
- report_pending is single-deep:
  - A 'T' or auto-request during a report sets it, and it is serviced immediately after the current report.
  - Multiple requests during one report collapse into one follow-up report.
  - A request in the same cycle as the TX_IDLE snapshot sets pending again, giving one follow-up report.
- AUTO_REPORT=1: a registered previous-time copy is kept, and any change in time_i sets report_pending. The previous-time copy resets to 0.
- Command latency: a 'B' byte at edge N gives button_o in cycle N+1. A 'T' byte at edge N gives the snapshot at N+2 and the first txclk_o at N+3 if txready_i=1.
- RX and TX FSMs run independently. Button pulses and errors occur during transmission.
- Reset mid-report aborts immediately. No partial byte is strobed after reset.

Decomposition:
- stopwatch_pkg holds:
  - state_t (IDLE=3'b100, RUNNING=3'b001, CLEAR=3'b010), moved out of top.
  - Command byte constants (CMD_BTN_U, CMD_BTN_L, CMD_RPT_U, CMD_RPT_L, ASCII_CR, ASCII_LF).
  - Mode character constants.
  - REPORT_LEN=4.
- Sub-module bin2dec2: combinational TIME_W-bit binary to two BCD digits, saturating at 99. It is instantiated once, on the snapshot.

Test Plan:
- Reset low 3 cycles with rxready_i=1 and rxdata_i='B' → all outputs 0 and no rxclk_o. Release → rxclk_o and button_o both high exactly one cycle, at edge+1.
- Byte 'x' (0x78) → rxclk_o pulse, rx_err_o one-cycle pulse, button_o stays 0. Byte 0x0D → rxclk_o pulse only.
- mode_i=3'b001, time_i=17, send 'T', UART model drops txready_i for 10 cycles per byte → txdata_o sequence 0x52, 0x31, 0x37, 0x0D, one txclk_o per byte, no strobe while txready_i=0.
- Start a report with time_i=5, change time_i to 9 and send 'T' twice mid-report → first report "?05" with CR only if the mode is unknown, otherwise the mode char followed by '0','5',CR. Exactly one follow-up report shows '0','9'.
- AUTO_REPORT=1, time_i increments 30→31 with mode IDLE → report 'I','3','1',CR. No report while time_i is static.
- Assert nRst_i=0 after the second byte of a report → no further txclk_o. After release, FSM idle and no pending report.
